// File: rtl/store_datapath_if.sv
// Output word stream of the SHAKE store stage: w-bit words on a valid/ready handshake.
interface store_datapath_if #(parameter int W = 64);
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;

  modport master (output data_out, data_out_valid, input data_out_ready);
  modport slave  (input data_out, data_out_valid, output data_out_ready);
endinterface

// File: rtl/store_datapath.sv
// SHAKE squeeze stage: captures a permuted rate block and streams it out as byte-swapped,
// length-masked w-bit words, requesting further permutations until output_size bits are sent.
module store_datapath #(
  parameter int         W             = 64,
  parameter int         RATE          = 1344,
  parameter logic [1:0] SHAKE128_MODE = 2'b10,
  parameter logic [1:0] SHAKE256_MODE = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     output_size,
  input  logic [1:0]      operation_mode,
  input  logic [RATE-1:0] block_in,
  input  logic            block_valid,
  output logic            block_ready,
  output logic            squeeze_req,
  output logic            busy,
  output logic            done,
  store_datapath_if.master dout
);
  localparam int NUM_LANES = RATE / W;
  localparam int IW        = $clog2(NUM_LANES + 1);
  localparam int SW        = $clog2(W);
  localparam logic [IW-1:0] WORDS_256 = IW'(17);
  localparam logic [IW-1:0] WORDS_128 = IW'(21);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BLOCK, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     size_rem;
  logic [1:0]      mode_q;
  logic [IW-1:0]   word_idx;
  logic [RATE-1:0] piso;
  logic            squeeze_q;
  logic [W-1:0]    swp, mask;
  logic [IW-1:0]   max_words;
  logic            xfer, last_word, blk_end;

  assign max_words = (mode_q == SHAKE256_MODE) ? WORDS_256 : WORDS_128;
  assign xfer      = (state == S_DRAIN) && dout.data_out_ready;
  assign last_word = size_rem <= 32'(W);
  assign blk_end   = word_idx == max_words - IW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = (output_size != 32'd0) ? S_WAIT_BLOCK : S_DONE;
      S_WAIT_BLOCK: if (block_valid) state_nxt = S_DRAIN;
      S_DRAIN:      if (xfer) state_nxt = last_word ? S_DONE : (blk_end ? S_WAIT_BLOCK : S_DRAIN);
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // The PISO shifts down one lane per transfer, so the current word is always the low lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      size_rem  <= '0;
      mode_q    <= '0;
      word_idx  <= '0;
      piso      <= '0;
      squeeze_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      squeeze_q <= xfer && !last_word && blk_end;
      if (state == S_IDLE && start) begin
        size_rem <= output_size;
        mode_q   <= operation_mode;
      end
      if (state == S_WAIT_BLOCK && block_valid) begin
        piso     <= block_in;
        word_idx <= '0;
      end else if (xfer) begin
        piso     <= piso >> W;
        word_idx <= word_idx + IW'(1);
        size_rem <= last_word ? 32'd0 : size_rem - 32'(W);
      end
    end
  end

  for (genvar b = 0; b < W / 8; b++) begin : g_swap
    assign swp[8*b +: 8] = piso[W-8-8*b +: 8];
  end

  // Final partial word keeps only its top size_rem bits (MSB-first stream order).
  always_comb begin
    mask = '1;
    if (size_rem < 32'(W)) mask = ~({W{1'b1}} >> size_rem[SW-1:0]);
  end

  assign dout.data_out_valid = (state == S_DRAIN);
  assign dout.data_out       = (state == S_DRAIN) ? (swp & mask) : '0;
  assign block_ready         = (state == S_WAIT_BLOCK);
  assign squeeze_req         = squeeze_q;
  assign busy                = (state != S_IDLE);
  assign done                = (state == S_DONE);
endmodule

// File: tb/tb_store_datapath.sv
// Table-driven and randomized bench for store_datapath against a word-stream reference model.
module tb_store_datapath;
  localparam logic [1:0] M128 = 2'b10;
  localparam logic [1:0] M256 = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   output_size;
  logic [1:0]    operation_mode;
  logic [1343:0] block_in;
  logic          block_valid;
  logic          block_ready, squeeze_req, busy, done;

  store_datapath_if #(.W(64)) bus ();

  store_datapath dut (
    .clk(clk), .rst(rst), .start(start), .output_size(output_size),
    .operation_mode(operation_mode), .block_in(block_in), .block_valid(block_valid),
    .block_ready(block_ready), .squeeze_req(squeeze_req), .busy(busy), .done(done),
    .dout(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1343:0] blks[$];

  typedef struct {
    string       name;
    logic [31:0] size;
    logic [1:0]  mode;
    int          stall;
    int          fill;
    int          words;
    int          sq;
    bit          has_last;
    logic [63:0] last;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [1343:0] make_block(input int fill);
    logic [1343:0] b;
    for (int i = 0; i < 42; i++) b[32*i +: 32] = $urandom;
    if (fill == 1) b = '1;
    if (fill == 2) for (int i = 0; i < 21; i++) b[64*i +: 64] = 64'h0123456789ABCDEF;
    return b;
  endfunction

  // Word n of the stream: lane n%maxw of block n/maxw, byte-reversed, cut to the bits still owed.
  function automatic logic [63:0] model_word(input int n, input logic [31:0] size, input int maxw);
    logic [1343:0] b;
    logic [63:0]   lane, r;
    longint        rem;
    b    = blks[n / maxw];
    lane = b[64*(n % maxw) +: 64];
    for (int k = 0; k < 8; k++) r[8*k +: 8] = lane[8*(7-k) +: 8];
    rem = longint'({32'd0, size}) - 64 * longint'(n);
    for (int i = 0; i < 64; i++) if (longint'(63 - i) >= rem) r[i] = 1'b0;
    return r;
  endfunction

  task automatic run(input vec_t v);
    int maxw, total, nw, nsq, cyc;
    bit last_prev, stalled, seen_done, saw_ready, rdy;
    logic [63:0] held, lastw, expw;
    maxw  = (v.mode == M256) ? 17 : 21;
    total = int'((longint'({32'd0, v.size}) + 63) / 64);
    nw = 0; nsq = 0; cyc = 0;
    last_prev = 0; stalled = 0; seen_done = 0; saw_ready = 0;
    held = '0; lastw = '0;
    blks.delete();
    @(negedge clk);
    start = 1'b1; output_size = v.size; operation_mode = v.mode;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_busy_after_start"}, 64'(busy), 64'd1);
    while (cyc < 4000) begin
      if (squeeze_req) begin
        nsq++;
        chk({v.name, "_squeeze_with_ready"}, 64'(block_ready), 64'd1);
      end
      if (last_prev || done) begin
        chk({v.name, "_done"}, 64'(done), 64'd1);
        chk({v.name, "_done_after_last"}, 64'(last_prev), 64'(total != 0));
        chk({v.name, "_busy_in_done"}, 64'(busy), 64'd1);
        seen_done = 1;
        break;
      end
      if (block_ready) begin
        saw_ready = 1;
        block_in = make_block(v.fill);
        blks.push_back(block_in);
        block_valid = 1'b1;
      end else begin
        block_in = make_block(0);
        block_valid = 1'($urandom % 2);
      end
      if (bus.data_out_valid) begin
        expw = model_word(nw, v.size, maxw);
        chk({v.name, "_word"}, bus.data_out, expw);
        if (stalled) chk({v.name, "_stall_hold"}, bus.data_out, held);
        rdy = ($urandom % 100) >= v.stall;
        held = bus.data_out;
        stalled = !rdy;
        if (rdy) begin
          lastw = bus.data_out;
          nw++;
          if (nw == total) last_prev = 1;
        end
      end else begin
        rdy = 1'($urandom % 2);
        stalled = 0;
      end
      bus.data_out_ready = rdy;
      start = ($urandom % 4) == 0;
      output_size = $urandom;
      operation_mode = 2'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; block_valid = 1'b0; bus.data_out_ready = 1'b0;
    chk({v.name, "_done_seen"}, 64'(seen_done), 64'd1);
    chk({v.name, "_word_count"}, 64'(nw), 64'(v.words));
    chk({v.name, "_squeeze_count"}, 64'(nsq), 64'(v.sq));
    if (v.has_last) chk({v.name, "_last_word"}, lastw, v.last);
    if (v.size == 0) chk({v.name, "_no_block_ready"}, 64'(saw_ready), 64'd0);
    @(negedge clk);
    chk({v.name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({v.name, "_idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t rv;
    int   words, maxw;
    tbl[0] = '{"s256_256",   32'd256,  M256,  0, 2,  4, 0, 1'b1, 64'hEFCDAB8967452301};
    tbl[1] = '{"s128_1408",  32'd1408, M128,  0, 0, 22, 1, 1'b0, 64'h0};
    tbl[2] = '{"s256_1089",  32'd1089, M256,  0, 2, 18, 1, 1'b1, 64'h8000000000000000};
    tbl[3] = '{"s128_100",   32'd100,  M128,  0, 1,  2, 0, 1'b1, 64'hFFFFFFFFF0000000};
    tbl[4] = '{"stall_1344", 32'd1344, M128, 50, 0, 21, 0, 1'b0, 64'h0};
    tbl[5] = '{"zero",       32'd0,    M128,  0, 0,  0, 0, 1'b0, 64'h0};
    tbl[6] = '{"other_1400", 32'd1400, 2'b00, 20, 0, 22, 1, 1'b0, 64'h0};
    tbl[7] = '{"s256_3000",  32'd3000, M256, 50, 0, 47, 2, 1'b0, 64'h0};
    tbl[8] = '{"s128_63",    32'd63,   M128, 30, 1,  1, 0, 1'b1, 64'hFFFFFFFFFFFFFFFE};

    rst = 1'b0; start = 1'b0; output_size = '0; operation_mode = M128;
    block_in = '0; block_valid = 1'b0; bus.data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_block_ready", 64'(block_ready), 64'd0);
    chk("reset_valid", 64'(bus.data_out_valid), 64'd0);
    chk("reset_data", bus.data_out, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done_squeeze", 64'({done, squeeze_req}), 64'd0);
    rst = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Reset in the middle of a drain, then a normal short request.
    @(negedge clk);
    start = 1'b1; output_size = 32'd1344; operation_mode = M128;
    @(negedge clk);
    start = 1'b0; block_in = make_block(0); block_valid = 1'b1; bus.data_out_ready = 1'b1;
    @(negedge clk);
    block_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_valid_before", 64'(bus.data_out_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.data_out_valid), 64'd0);
    chk("midrst_data", bus.data_out, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready_sq_done", 64'({block_ready, squeeze_req, done}), 64'd0);
    @(negedge clk);
    rst = 1'b1; bus.data_out_ready = 1'b0;
    rv = '{"after_rst_64", 32'd64, M256, 0, 0, 1, 0, 1'b0, 64'h0};
    run(rv);

    for (int r = 0; r < 6; r++) begin
      rv.name  = "rand";
      rv.size  = $urandom_range(1, 3000);
      rv.mode  = 2'($urandom);
      rv.stall = 30;
      rv.fill  = 0;
      maxw     = (rv.mode == M256) ? 17 : 21;
      words    = int'((rv.size + 32'd63) / 32'd64);
      rv.words = words;
      rv.sq    = (words - 1) / maxw;
      rv.has_last = 1'b0;
      rv.last  = '0;
      run(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_datapath.md
Name: store_datapath

Overview:
- Output stage of the SHAKE core, directly downstream of the Keccak permutation.
- Takes a full rate block from the permutation state and serializes it into w-bit words on a valid/ready stream.
- Stops after output_size bits. Requests extra permutations (squeeze) whenever the requested length is longer than one rate block.
- Control values (output_size, operation_mode) come from the load stage's control registers.

Parameters:
- w, 64, output word width in bits (from keccak_pkg).
- RATE, RATE_SHAKE128 (1344), width of the block input bus.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; latches output_size and operation_mode
- output_size  in  32  requested output length in bits
- operation_mode  in  2  SHAKE128_MODE_VEC / SHAKE256_MODE_VEC
- block_in  in  RATE  rate portion of the permutation state; lane k = block_in[64k+63:64k]
- block_valid  in  1  block_in holds a fresh permuted state
- block_ready  out  1  stage accepts block_in this cycle
- squeeze_req  out  1  one-cycle pulse requesting another permutation
- data_out  out  w  output word
- data_out_valid  out  1  data_out is valid
- data_out_ready  in  1  downstream accepts data_out
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse after the final word transfers

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0; FSM goes to IDLE; all counters and registers clear.
  - This applies mid-operation too: any partial output is discarded.
- Block depth: max_words = 17 for SHAKE256_MODE_VEC, 21 for SHAKE128_MODE_VEC and for any other encoding. Depth is fixed from the mode latched at start.
- FSM states:
  - IDLE:
    - start with output_size != 0 -> latch size and mode, go to WAIT_BLOCK.
    - start with output_size == 0 -> DONE.
    - start is ignored in every state other than IDLE.
  - WAIT_BLOCK:
    - block_ready = 1.
    - On block_valid & block_ready: capture block_in into the internal PISO register, word_idx = 0, go to DRAIN.
  - DRAIN:
    - data_out_valid = 1.
    - A word transfers on data_out_valid & data_out_ready.
    - On each transfer: remaining -= w (saturating at 0); word_idx += 1.
    - Transfer with remaining <= w (last word) -> DONE.
    - Transfer of word_idx == max_words-1 with remaining > w -> pulse squeeze_req the next cycle, go to WAIT_BLOCK.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: block accepted at cycle N -> word 0 presented with data_out_valid at N+1. Best case is one word per cycle.
- Word formatting:
  - data_out = EndianSwitcher byte-swap of lane word_idx.
  - Output bit order is MSB-first stream order.
- Last-word masking: when remaining < w, keep the top `remaining` bits of data_out and zero the rest. Masking is bit-granular; non-byte multiples are legal.
- Backpressure: while data_out_valid & !data_out_ready, data_out and word_idx hold stable. Valid must never drop before the transfer completes.
- The remaining counter is 32-bit unsigned. output_size up to 2^32-1 is legal; the number of blocks is unbounded.
- block_valid outside WAIT_BLOCK is ignored; the block is not captured.
- busy is high from the cycle after start through the DONE cycle.

Test Plan:
- SHAKE256, output_size=256, block lanes 0..3 = 0x0123456789ABCDEF, ... -> 4 words, each the byte-swap of its lane (word0 = 0xEFCDAB8967452301); done 1 cycle after 4th transfer; no squeeze_req.
- SHAKE128, output_size=1408 -> 21 words; squeeze_req pulse; block_ready re-asserted; after 2nd block, 1 word (lane 0 of new block); done; 22 transfers total.
- SHAKE256, output_size=1089 -> 17 words, squeeze, 1 word whose top bit = lane-0 MSB of swapped word and low 63 bits = 0.
- output_size=100 with block lanes all-ones -> word0 = 0xFFFF_FFFF_FFFF_FFFF, word1 = 0xFFFF_FFFF_F000_0000 (top 36 bits kept).
- Random data_out_ready toggling (about 50%) during 21-word drain -> data_out stable while stalled; word sequence and count identical to the no-stall run.
- output_size=0 start -> done pulse next cycle, block_ready never high; rst low mid-DRAIN (word 5) -> all outputs 0 immediately; later start with output_size=64 completes normally.
